// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Shared types for the sequential ALU: opcode encoding,     |
// |            controller state encoding and the result flag bundle.     |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ADDC = 3'd5,
    OP_MUL  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_adder                                                |
// | Purpose  : One-bit full adder.                                       |
// | Ports    : a, b, ci (in) operand bits and carry-in                   |
// |            s, co    (out) sum bit and carry-out                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/rca_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rca_n                                                     |
// | Purpose  : WIDTH-bit ripple-carry adder built from full_adder cells. |
// | Ports    : a, b [WIDTH] (in) operands; ci (in) carry-in              |
// |            s [WIDTH] (out) sum;        co (out) carry-out            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rca_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = ci;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_carry[i]),
        .s  (s[i]),
        .co (w_carry[i+1])
      );
    end
  endgenerate

  assign co = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_seq                                                   |
// | Purpose  : Registered ALU with stored carry, shift-add multiplier    |
// |            and valid/ready handshakes on input and output.           |
// | Ports    : clk, rst (in)          clock, sync active-high reset      |
// |            in_valid/in_ready      operation handshake                |
// |            op [3], a, b [WIDTH]   opcode and operands                |
// |            out_valid/out_ready    result handshake                   |
// |            r [WIDTH], c, z, v, n  registered result and flags        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state_q,     state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   r_q,         r_d;
  flags_t             flags_q,     flags_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   mcand_q,     mcand_d;
  logic [WIDTH-1:0]   mplier_q,    mplier_d;
  logic [2*WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  op_e              w_op;
  logic [WIDTH-1:0] w_add_a, w_add_b, w_add_s;
  logic             w_add_ci, w_add_co;
  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_c, w_alu_v;
  logic             w_out_free, w_accept, w_load;

  assign w_op       = op_e'(op);
  assign w_out_free = !out_valid_q || out_ready;
  assign in_ready   = (state_q == ST_IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;

  // The single adder is shared. While multiplying, the product is built
  // with a right-shifting accumulator: the multiplicand is added into the
  // upper half and the whole accumulator (with carry-out) shifts right,
  // which is equivalent to shifting the multiplicand left each step but
  // needs only a WIDTH-bit adder.
  always_comb begin
    if (state_q == ST_MUL) begin
      w_add_a  = acc_q[2*WIDTH-1:WIDTH];
      w_add_b  = mplier_q[0] ? mcand_q : '0;
      w_add_ci = 1'b0;
    end else begin
      w_add_a  = a;
      w_add_b  = (w_op == OP_SUB) ? ~b : b;
      w_add_ci = (w_op == OP_SUB) | ((w_op == OP_ADDC) & carry_q);
    end
  end

  rca_n #(.WIDTH(WIDTH)) u_rca (
    .a  (w_add_a),
    .b  (w_add_b),
    .ci (w_add_ci),
    .s  (w_add_s),
    .co (w_add_co)
  );

  // Single-cycle result for the presented opcode; MUL and reserved give 0.
  always_comb begin
    w_alu_r = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_ADDC: begin
        w_alu_r = w_add_s;
        w_alu_c = w_add_co;
        // Overflow judged on the operand actually fed to the adder.
        w_alu_v = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                  (w_add_s[WIDTH-1] != w_add_a[WIDTH-1]);
      end
      OP_AND:  w_alu_r = a & b;
      OP_OR:   w_alu_r = a | b;
      OP_XOR:  w_alu_r = a ^ b;
      default: w_alu_r = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    flags_d  = flags_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    w_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            w_load    = 1'b1;
            r_d       = w_alu_r;
            flags_d.c = w_alu_c;
            flags_d.z = (w_alu_r == '0);
            flags_d.v = w_alu_v;
            flags_d.n = w_alu_r[WIDTH-1];
            carry_d   = w_alu_c;
          end
        end
      end
      ST_MUL: begin
        acc_d    = {w_add_co, w_add_s, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_out_free) begin
          w_load    = 1'b1;
          r_d       = acc_q[WIDTH-1:0];
          flags_d.c = |acc_q[2*WIDTH-1:WIDTH];
          flags_d.z = (acc_q[WIDTH-1:0] == '0);
          flags_d.v = |acc_q[2*WIDTH-1:WIDTH];
          flags_d.n = acc_q[WIDTH-1];
          carry_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load wins over a consume in the same cycle.
    if (w_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      flags_q     <= '0;
      carry_q     <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      flags_q     <= flags_d;
      carry_q     <= carry_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign c         = flags_q.c;
  assign z         = flags_q.z;
  assign v         = flags_q.v;
  assign n         = flags_q.n;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                |
// | Purpose  : Self-checking bench for alu_seq: directed sequences with  |
// |            literal expectations plus randomized traffic checked      |
// |            every cycle against an arithmetic reference model.        |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W    = 8;
  localparam int SMAX = (1 << (W-1)) - 1;
  localparam int SMIN = -(1 << (W-1));

  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR = 3'd3,
                         T_XOR = 3'd4, T_ADDC = 3'd5, T_MUL = 3'd6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, c, z, v, n;
  logic [W-1:0] r;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .c         (c),
    .z         (z),
    .v         (v),
    .n         (n)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] r;
    logic c, z, v, n;
    logic carry;
  } res_t;

  function automatic res_t ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic cin);
    int     ux = x;
    int     uy = y;
    int     sx = $signed(x);
    int     sy = $signed(y);
    int     s, ss;
    longint p;
    res_t   t;
    t = '0;
    case (o)
      T_ADD: begin
        s = ux + uy;            ss = sx + sy;
        t.r = s[W-1:0];         t.c = (s >= (1 << W)); t.v = (ss > SMAX) || (ss < SMIN);
      end
      T_SUB: begin
        s = ux - uy;            ss = sx - sy;
        t.r = s[W-1:0];         t.c = (ux >= uy);      t.v = (ss > SMAX) || (ss < SMIN);
      end
      T_ADDC: begin
        s = ux + uy + int'(cin); ss = sx + sy + int'(cin);
        t.r = s[W-1:0];         t.c = (s >= (1 << W)); t.v = (ss > SMAX) || (ss < SMIN);
      end
      T_AND: t.r = x & y;
      T_OR:  t.r = x | y;
      T_XOR: t.r = x ^ y;
      T_MUL: begin
        p   = longint'(ux) * longint'(uy);
        t.r = p[W-1:0];
        t.c = ((p >> W) != 0);
        t.v = t.c;
      end
      default: t.r = '0;
    endcase
    t.z     = (t.r == '0);
    t.n     = t.r[W-1];
    t.carry = (o == T_ADD || o == T_SUB || o == T_ADDC) ? t.c : 1'b0;
    return t;
  endfunction

  logic m_ov = 1'b0;
  res_t m_out = '0;
  logic m_carry = 1'b0;
  int   m_mul_cnt = 0;      // multiply cycles still to run
  logic m_mul_done = 1'b0;  // product computed, waiting for the output slot
  res_t m_mul_res = '0;
  logic m_acc, m_ld;
  res_t m_new;

  function automatic logic m_ready();
    return (m_mul_cnt == 0) && !m_mul_done && (!m_ov || out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ov = 1'b0; m_out = '0; m_carry = 1'b0;
      m_mul_cnt = 0; m_mul_done = 1'b0;
    end else begin
      m_acc = in_valid && m_ready();
      m_ld  = 1'b0;
      m_new = '0;
      if (m_mul_done && (!m_ov || out_ready)) begin
        m_ld = 1'b1; m_new = m_mul_res; m_mul_done = 1'b0;
      end else if (m_mul_cnt > 0) begin
        m_mul_cnt--;
        if (m_mul_cnt == 0) m_mul_done = 1'b1;
      end
      if (m_acc) begin
        if (op == T_MUL) begin
          m_mul_cnt = W;
          m_mul_res = ref_op(T_MUL, a, b, 1'b0);
        end else begin
          m_ld  = 1'b1;
          m_new = ref_op(op, a, b, m_carry);
        end
      end
      if (m_ld) begin
        m_ov = 1'b1; m_out = m_new; m_carry = m_new.carry;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("r", r, m_out.r);
        chk("flags_cZvn", {c, z, v, n}, {m_out.c, m_out.z, m_out.v, m_out.n});
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic g;
    in_valid = 1'b1; op = o; a = x; b = y;
    g = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1 g = in_ready;
      @(posedge clk); #1;
      if (g) break;
    end
    in_valid = 1'b0;
    if (!g) chk("accept_timeout", 0, 1);
  endtask

  task automatic expect_res(input string name, input logic [W-1:0] er, input logic [3:0] ef);
    #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_r"}, r, er);
    chk({name, "_flags"}, {c, z, v, n}, ef);
  endtask

  // Waits for a multiply result after acceptance; returns cycles to out_valid.
  task automatic wait_mul(input string name);
    int   k;
    int   first;
    logic ir_low;
    first  = 0;
    ir_low = 1'b1;
    for (k = 1; k <= 20; k++) begin
      #1;
      if (out_valid) begin first = k; break; end
      if (in_ready) ir_low = 1'b0;
      @(posedge clk); #1;
    end
    chk({name, "_latency"}, first, 10);
    chk({name, "_in_ready_low"}, ir_low, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_r", r, 0);
    chk("rst_flags", {c, z, v, n}, 4'b0000);

    issue(T_ADD, 8'h7F, 8'h01);  expect_res("add_ovf", 8'h80, 4'b0011);
    issue(T_SUB, 8'h05, 8'h05);  expect_res("sub_eq", 8'h00, 4'b1100);
    issue(T_SUB, 8'h00, 8'h01);  expect_res("sub_borrow", 8'hFF, 4'b0001);
    issue(T_ADD, 8'hFF, 8'h01);  expect_res("add_carry", 8'h00, 4'b1100);
    issue(T_ADDC, 8'h00, 8'h00); expect_res("addc_fwd", 8'h01, 4'b0000);
    issue(T_AND, 8'hF0, 8'h3C);  expect_res("and", 8'h30, 4'b0000);
    issue(T_ADDC, 8'h01, 8'h01); expect_res("addc_clr", 8'h02, 4'b0000);

    issue(T_MUL, 8'h0C, 8'h0B);  wait_mul("mul_84"); expect_res("mul_84", 8'h84, 4'b0001);
    issue(T_MUL, 8'h10, 8'h10);  wait_mul("mul_ovf"); expect_res("mul_ovf", 8'h00, 4'b1110);

    // Back-pressure: result held stable while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(T_XOR, 8'hA5, 8'h0F);  expect_res("xor", 8'hAA, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      expect_res("hold", 8'hAA, 4'b0001);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Multiply completing while the consumer stalls.
    issue(T_MUL, 8'h03, 8'h05);
    out_ready = 1'b0;
    wait_mul("mul_stall");
    expect_res("mul_stall", 8'h0F, 4'b0000);
    @(posedge clk); #2;
    expect_res("mul_hold", 8'h0F, 4'b0000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset aborts a multiply in flight.
    issue(T_MUL, 8'h07, 8'h09);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_r", r, 0);
    chk("abort_flags", {c, z, v, n}, 4'b0000);
    issue(T_ADDC, 8'h01, 8'h01); expect_res("abort_addc", 8'h02, 4'b0000);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] pick [6];
      pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h7F;
      pick[3] = 8'h80; pick[4] = 8'hFF; pick[5] = W'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = ($urandom_range(0, 1) != 0) ? W'($urandom) : pick[$urandom_range(0, 5)];
      b         = ($urandom_range(0, 1) != 0) ? W'($urandom) : pick[$urandom_range(0, 5)];
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2 * W + 4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU. It accepts one operation per handshake, computes the result with WIDTH-bit arithmetic, and holds the result and flags in an output register until the consumer takes them. It adds three things the combinational ALU lacks: a stored carry for add-with-carry chains, a multi-cycle shift-add multiplier, and valid/ready flow control on both input and output. It sits between the operand/decode stage and the writeback stage.

## Interface
- WIDTH, 8, operand and result width; must be ≥ 2.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- op  in  3  operation code (alu_pkg encoding).
- a, b  in  WIDTH  operands, unsigned or two's complement.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- r  out  WIDTH  result.
- c, z, v, n  out  1 each  carry, zero, signed overflow, negative flags for r.

## Operation
- Opcodes:
  - ADD=0: r = a + b.
  - SUB=1: r = a + ~b + 1. Carry out means no borrow.
  - AND=2, OR=3, XOR=4: bitwise.
  - ADDC=5: r = a + b + carry_q.
  - MUL=6: r = low WIDTH bits of the unsigned product a*b.
  - 7: reserved.
- carry_q (internal):
  - ADD/SUB/ADDC write it with the adder carry-out.
  - All other ops clear it to 0.
  - It is updated when the result is loaded into the output register.
- Flags (all registered together with r):
  - z = (r == 0).
  - n = r[WIDTH-1].
  - Add ops: c = carry-out. v = (a_msb == b'_msb) && (r_msb != a_msb), where b' is the operand actually fed to the adder (~b for SUB).
  - Logic ops: c = 0, v = 0.
  - MUL: c = v = 1 if the high half of the 2·WIDTH-bit product is nonzero, else 0.
- Reserved op 7: r = 0, z = 1, c = v = n = 0, single-cycle.
- FSM states:
  - IDLE:
    - in_ready = !out_valid || out_ready.
    - An accepted non-MUL op loads the output register at the same edge.
    - An accepted MUL latches a and b, clears the accumulator and goes to MUL.
  - MUL:
    - in_ready = 0.
    - Runs WIDTH iterations: if multiplier LSB is 1, accumulator += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. A 2·WIDTH-bit accumulator is kept for the overflow flag.
    - After the last iteration, go to WAIT.
  - WAIT:
    - If !out_valid || out_ready, load the output register with the product and flags and go to IDLE.
    - Otherwise stay.
- Output register:
  - out_valid sets on load.
  - out_valid clears on out_ready when no new load occurs in the same cycle.
  - A load and a consume in the same cycle keep out_valid = 1 with the new contents.
  - r and flags stay stable while out_valid && !out_ready.
- op, a and b are sampled only on in_valid && in_ready. Inputs are ignored otherwise.

## Timing
- Reset values:
  - State IDLE.
  - out_valid = 0, r = 0, c = z = v = n = 0.
  - carry_q = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset during MUL or WAIT aborts the operation. The product is discarded and the state above applies next cycle.
- Non-MUL latency:
  - Accepted at edge t, result visible after edge t.
  - Throughput is 1 per cycle when out_ready is held high.
- MUL latency:
  - Accepted at edge t, result visible after edge t+WIDTH+1, provided out_ready is high or the output register is empty.
  - in_ready is 0 from t+1 until the load edge.
- ADDC accepted in the same cycle as a result load uses the carry_q being written at that edge, i.e. the immediately preceding op's carry. The carry path therefore forwards without a bubble.

## Structure
- alu_pkg holds:
  - The op enum (ADD…MUL, reserved).
  - The FSM state enum.
  - A flags struct {c, z, v, n}.
- One sub-module, rca_n: a WIDTH-parametrised ripple-carry adder with carry-in and carry-out, built from the existing full_adder.
- MUL reuses rca_n for its accumulate step. There is no separate multiplier array.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 -> next cycle r=0x80, n=1, v=1, c=0, z=0.
- SUB 0x05-0x05 -> r=0x00, z=1, c=1, v=0. SUB 0x00-0x01 -> r=0xFF, c=0, n=1.
- ADD 0xFF+0x01 (r=0x00, c=1), then back-to-back ADDC 0x00+0x00 -> r=0x01, c=0. Then AND 0xF0&0x3C -> r=0x30, and a following ADDC 0x01+0x01 -> r=0x02 (carry was cleared).
- MUL 0x0C×0x0B -> r=0x84, c=v=0, out_valid exactly 9 cycles after accept, in_ready low throughout. MUL 0x10×0x10 -> r=0x00, z=1, c=v=1.
- Back-pressure:
  - Hold out_ready=0 for 3 cycles with out_valid=1 -> r and flags stable, in_ready=0.
  - MUL completing into a full output register stays in WAIT until out_ready, then loads.
- Assert rst 4 cycles into a MUL -> next cycle out_valid=0, in_ready=1, flags 0. A following ADDC 0x01+0x01 -> r=0x02.
